// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle control FSM for the rv32i core.
// Steps one instruction at a time through FETCH, DECODE, EXEC, MEM and WB.
// Holds the program counter and the instruction register.
// Drives the instruction/data memory handshakes and the register-file write strobe.
// Halts in TRAP on an illegal opcode, on SYSTEM, or on a misaligned control-flow target.
module core_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] ir,
   output logic [31:0] pc,
   input  logic [31:0] target,
   input  logic        branch_taken,
   output logic        dmem_req,
   output logic        dmem_we,
   input  logic        dmem_ack,
   output logic        rf_we,
   output logic        retire,
   output logic        trap
);

   localparam logic [6:0] OP_LUI     = 7'b0110111;
   localparam logic [6:0] OP_AUIPC   = 7'b0010111;
   localparam logic [6:0] OP_JAL     = 7'b1101111;
   localparam logic [6:0] OP_JALR    = 7'b1100111;
   localparam logic [6:0] OP_BRANCH  = 7'b1100011;
   localparam logic [6:0] OP_LOAD    = 7'b0000011;
   localparam logic [6:0] OP_STORE   = 7'b0100011;
   localparam logic [6:0] OP_OPIMM   = 7'b0010011;
   localparam logic [6:0] OP_OP      = 7'b0110011;
   localparam logic [6:0] OP_MISCMEM = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM  = 7'b1110011;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
   } state_t;

   typedef enum logic [2:0] {
      C_ALU, C_JAL, C_JALR, C_BRANCH, C_LOAD, C_STORE, C_MISCMEM, C_ILLEGAL
   } opclass_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ir_q, ir_d;

   opclass_t    op_class;
   logic [31:0] pc_plus4;
   logic [31:0] branch_pc;
   logic [31:0] jump_pc;
   logic        branch_misaligned;
   logic        jump_misaligned;

   // Classify the latched instruction by opcode; SYSTEM is folded into ILLEGAL.
   always_comb begin
      // NOTE: every signal written in a combinational block gets a default first, so no latch is inferred.
      op_class = C_ILLEGAL;
      case (ir_q[6:0])
         OP_LUI, OP_AUIPC, OP_OPIMM, OP_OP: op_class = C_ALU;
         OP_JAL:                            op_class = C_JAL;
         OP_JALR:                           op_class = C_JALR;
         OP_BRANCH:                         op_class = C_BRANCH;
         OP_LOAD:                           op_class = C_LOAD;
         OP_STORE:                          op_class = C_STORE;
         OP_MISCMEM:                        op_class = C_MISCMEM;
         OP_SYSTEM:                         op_class = C_ILLEGAL;
         default:                           op_class = C_ILLEGAL;
      endcase
   end

   // Candidate next-pc values; target is produced from the stable ir/pc, so it holds from EXEC through WB.
   assign pc_plus4          = pc_q + 32'd4;
   assign branch_pc         = branch_taken ? target : pc_plus4;
   assign jump_pc           = (op_class == C_JALR) ? {target[31:1], 1'b0} : target;
   assign branch_misaligned = (branch_pc[1:0] != 2'b00);
   assign jump_misaligned   = (jump_pc[1:0] != 2'b00);

   // State, pc and ir registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         state_q <= S_FETCH;
         pc_q    <= RESET_PC;
         ir_q    <= NOP_INSTR;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
      end
   end

   // Next-state, next-pc and instruction latch logic.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      case (state_q)
         S_FETCH: begin
            if (imem_ack) begin
               ir_d    = imem_rdata;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            state_d = (op_class == C_ILLEGAL) ? S_TRAP : S_EXEC;
         end
         S_EXEC: begin
            case (op_class)
               C_LOAD, C_STORE: state_d = S_MEM;
               C_BRANCH: begin
                  if (branch_misaligned) begin
                     state_d = S_TRAP;
                  end else begin
                     pc_d    = branch_pc;
                     state_d = S_FETCH;
                  end
               end
               C_MISCMEM: begin
                  pc_d    = pc_plus4;
                  state_d = S_FETCH;
               end
               // Jump targets are validated here so WB never has to suppress its strobes.
               C_JAL, C_JALR: state_d = jump_misaligned ? S_TRAP : S_WB;
               default:       state_d = S_WB;
            endcase
         end
         S_MEM: begin
            if (dmem_ack) begin
               if (op_class == C_STORE) begin
                  pc_d    = pc_plus4;
                  state_d = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end
         end
         S_WB: begin
            pc_d    = (op_class == C_JAL || op_class == C_JALR) ? jump_pc : pc_plus4;
            state_d = S_FETCH;
         end
         S_TRAP:  state_d = S_TRAP;
         default: state_d = S_TRAP;
      endcase
   end

   // Handshake and strobe outputs decoded from the state register, all forced low while reset is held.
   always_comb begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      rf_we    = 1'b0;
      retire   = 1'b0;
      trap     = 1'b0;
      if (rst_n) begin
         case (state_q)
            S_FETCH: imem_req = 1'b1;
            S_EXEC: begin
               retire = (op_class == C_MISCMEM) ||
                        (op_class == C_BRANCH && !branch_misaligned);
            end
            S_MEM: begin
               dmem_req = 1'b1;
               dmem_we  = (op_class == C_STORE);
               retire   = (op_class == C_STORE) && dmem_ack;
            end
            S_WB: begin
               rf_we  = 1'b1;
               retire = 1'b1;
            end
            S_TRAP:  trap = 1'b1;
            default: trap = 1'b0;
         endcase
      end
   end

   assign imem_addr = pc_q;
   assign pc        = pc_q;
   assign ir        = ir_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Testbench for core_sequencer: directed program plus randomized instruction stream.
// The driver acts as instruction/data memory and pushes expected outcomes from an
// instruction-level reference model; a negedge monitor pops them on retire or trap.
module tb_core_sequencer;

   localparam logic [31:0] RST_PC = 32'h0000_0100;

   localparam logic [6:0] OP_LUI     = 7'b0110111;
   localparam logic [6:0] OP_AUIPC   = 7'b0010111;
   localparam logic [6:0] OP_JAL     = 7'b1101111;
   localparam logic [6:0] OP_JALR    = 7'b1100111;
   localparam logic [6:0] OP_BRANCH  = 7'b1100011;
   localparam logic [6:0] OP_LOAD    = 7'b0000011;
   localparam logic [6:0] OP_STORE   = 7'b0100011;
   localparam logic [6:0] OP_OPIMM   = 7'b0010011;
   localparam logic [6:0] OP_OP      = 7'b0110011;
   localparam logic [6:0] OP_MISCMEM = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM  = 7'b1110011;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic [31:0] ir;
   logic [31:0] pc;
   logic [31:0] target = 32'h0;
   logic        branch_taken = 1'b0;
   logic        dmem_req;
   logic        dmem_we;
   logic        dmem_ack = 1'b0;
   logic        rf_we;
   logic        retire;
   logic        trap;

   always #5 clk = ~clk;

   core_sequencer #(.RESET_PC(RST_PC)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ack     (imem_ack),
      .imem_rdata   (imem_rdata),
      .ir           (ir),
      .pc           (pc),
      .target       (target),
      .branch_taken (branch_taken),
      .dmem_req     (dmem_req),
      .dmem_we      (dmem_we),
      .dmem_ack     (dmem_ack),
      .rf_we        (rf_we),
      .retire       (retire),
      .trap         (trap)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] next_pc;
      logic        is_trap;
      logic        rf_we;
      logic        is_mem;
      logic        is_store;
      logic [7:0]  lat;
   } exp_t;

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_pass = 0;
   logic [31:0] m_pc = RST_PC;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
   endtask

   // Instruction-level reference: what one instruction does, its latency and where it goes next.
   function automatic exp_t model(input logic [31:0] cur_pc, input logic [31:0] instr,
                                  input logic [31:0] tgt, input logic tkn,
                                  input int iw, input int dw);
      exp_t        e;
      logic [31:0] npc;
      e      = '0;
      e.pc   = cur_pc;
      npc    = cur_pc + 32'd4;
      case (instr[6:0])
         OP_LUI, OP_AUIPC, OP_OPIMM, OP_OP: begin e.rf_we = 1'b1; e.lat = 8'(4 + iw); end
         OP_JAL:     begin npc = tgt; e.rf_we = 1'b1; e.lat = 8'(4 + iw); end
         OP_JALR:    begin npc = tgt & ~32'd1; e.rf_we = 1'b1; e.lat = 8'(4 + iw); end
         OP_BRANCH:  begin if (tkn) npc = tgt; e.lat = 8'(3 + iw); end
         OP_MISCMEM: e.lat = 8'(3 + iw);
         OP_LOAD:    begin e.rf_we = 1'b1; e.is_mem = 1'b1; e.lat = 8'(5 + iw + dw); end
         OP_STORE:   begin e.is_mem = 1'b1; e.is_store = 1'b1; e.lat = 8'(4 + iw + dw); end
         default:    e.is_trap = 1'b1;
      endcase
      if (npc[1:0] != 2'b00) e.is_trap = 1'b1;
      if (e.is_trap) begin
         e.rf_we   = 1'b0;
         e.next_pc = cur_pc;
      end else begin
         e.next_pc = npc;
      end
      return e;
   endfunction

   task automatic wait_imem(output bit ok);
      int n = 0;
      while (!imem_req && n < 20) begin @(posedge clk); #1; n++; end
      ok = imem_req;
   endtask

   task automatic wait_dmem(output bit ok);
      int n = 0;
      while (!dmem_req && n < 20) begin @(posedge clk); #1; n++; end
      ok = dmem_req;
   endtask

   task automatic do_reset(input int cycles);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      rst_n    = 1'b0;
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      repeat (cycles) begin @(posedge clk); #1; end
      check("rst_outputs", 32'({imem_req, dmem_req, dmem_we, rf_we, retire, trap}), 32'd0);
      check("rst_pc", pc, RST_PC);
      check("rst_ir", ir, 32'h0000_0013);
      rst_n = 1'b1;
      #1;
      m_pc = RST_PC;
   endtask

   // Serve one instruction: fetch handshake, optional data handshake, trap recovery.
   task automatic run_instr(input logic [31:0] instr, input logic [31:0] tgt, input logic tkn,
                            input int iw, input int dw);
      exp_t e;
      bit   ok;
      wait_imem(ok);
      if (!ok) begin
         check("fetch_timeout", 32'(imem_req), 32'd1);
         exp_q.delete();
         do_reset(1);
         return;
      end
      check("fetch_addr", imem_addr, m_pc);
      repeat (iw) begin @(posedge clk); #1; end
      imem_ack     = 1'b1;
      imem_rdata   = instr;
      target       = tgt;
      branch_taken = tkn;
      e = model(m_pc, instr, tgt, tkn, iw, dw);
      exp_q.push_back(e);
      @(posedge clk); #1;
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      check("ir_latch", ir, instr);
      if (e.is_mem && !e.is_trap) begin
         wait_dmem(ok);
         if (!ok) begin
            check("dmem_timeout", 32'(dmem_req), 32'd1);
            exp_q.delete();
            do_reset(1);
            return;
         end
         check("dmem_we", 32'(dmem_we), 32'(e.is_store));
         repeat (dw) begin @(posedge clk); #1; end
         dmem_ack = 1'b1;
         @(posedge clk); #1;
         dmem_ack = 1'b0;
      end
      if (e.is_trap) begin
         repeat (4) @(posedge clk);
         #1;
         check("trap_held", 32'(trap), 32'd1);
         do_reset(1 + $urandom_range(0, 1));
      end else begin
         m_pc = e.next_pc;
      end
   endtask

   function automatic bit is_legal(input logic [6:0] op);
      return op == OP_LUI || op == OP_AUIPC || op == OP_JAL || op == OP_JALR ||
             op == OP_BRANCH || op == OP_LOAD || op == OP_STORE || op == OP_OPIMM ||
             op == OP_OP || op == OP_MISCMEM || op == OP_SYSTEM;
   endfunction

   function automatic logic [6:0] pick_op(input int k);
      logic [6:0] op;
      case (k)
         0:       op = OP_LUI;
         1:       op = OP_AUIPC;
         2:       op = OP_JAL;
         3:       op = OP_JALR;
         4:       op = OP_BRANCH;
         5:       op = OP_LOAD;
         6:       op = OP_STORE;
         7:       op = OP_OPIMM;
         8:       op = OP_OP;
         9:       op = OP_MISCMEM;
         10:      op = OP_SYSTEM;
         12:      op = OP_OPIMM;
         13:      op = OP_BRANCH;
         default: begin
            op = 7'($urandom);
            while (is_legal(op)) op = 7'($urandom);
         end
      endcase
      return op;
   endfunction

   // Monitor: pops the scoreboard whenever the DUT retires or enters TRAP.
   initial begin
      int   cyc = 0;
      int   start_cyc = 0;
      bit   prev_req = 1'b0;
      bit   prev_trap = 1'b0;
      bit   pend_next = 1'b0;
      logic [31:0] pend_pc = 32'h0;
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            prev_req  = 1'b0;
            prev_trap = 1'b0;
            pend_next = 1'b0;
         end else begin
            if (pend_next) begin
               check("next_pc", pc, pend_pc);
               pend_next = 1'b0;
            end
            if (imem_req && !prev_req) start_cyc = cyc;
            prev_req = imem_req;
            if (rf_we) check("rf_we_only_with_retire", 32'(retire), 32'd1);
            if (retire) begin
               if (exp_q.size() == 0) begin
                  check("retire_expected", 32'(exp_q.size()), 32'd1);
               end else begin
                  e = exp_q.pop_front();
                  check("retire_not_trap", 32'(e.is_trap), 32'd0);
                  check("retire_pc", pc, e.pc);
                  check("retire_rf_we", 32'(rf_we), 32'(e.rf_we));
                  check("latency", 32'(cyc - start_cyc + 1), 32'(e.lat));
                  pend_next = 1'b1;
                  pend_pc   = e.next_pc;
               end
            end
            if (trap && !prev_trap) begin
               if (exp_q.size() == 0) begin
                  check("trap_expected", 32'(exp_q.size()), 32'd1);
               end else begin
                  e = exp_q.pop_front();
                  check("trap_wanted", 32'(e.is_trap), 32'd1);
                  check("trap_pc", pc, e.pc);
                  check("trap_quiet", 32'({imem_req, dmem_req, rf_we, retire}), 32'd0);
               end
            end
            prev_trap = trap;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks passed %0d of %0d", n_pass, n_checks);
      $fatal(1, "watchdog expired");
   end

   // Directed program, trap cases, reset during MEM, then randomized stream.
   initial begin
      bit          ok;
      logic [31:0] instr;
      logic [31:0] tgt;
      do_reset(2);

      run_instr(32'h0050_0093, 32'h0, 1'b0, 3, 0);           // ADDI, 3 fetch waits
      run_instr(32'h0050_0093, 32'h0, 1'b0, 0, 0);           // ADDI, zero wait
      run_instr(32'h0000_0063, 32'h0000_0200, 1'b1, 0, 0);   // BEQ taken
      run_instr(32'h0000_0063, 32'h0000_0404, 1'b0, 0, 0);   // BEQ not taken
      run_instr(32'h0000_a103, 32'h0, 1'b0, 0, 2);           // LW, ack after 2 waits
      run_instr(32'h0020_a023, 32'h0, 1'b0, 1, 1);           // SW
      run_instr(32'h0000_80e7, 32'h0000_0301, 1'b0, 0, 0);   // JALR, LSB cleared
      run_instr(32'h1234_50b7, 32'h0, 1'b0, 0, 0);           // LUI
      run_instr(32'h0000_0097, 32'h0, 1'b0, 2, 0);           // AUIPC
      run_instr(32'h0020_81b3, 32'h0, 1'b0, 0, 0);           // ADD
      run_instr(32'h0000_000f, 32'h0, 1'b0, 0, 0);           // FENCE
      run_instr(32'h0040_00ef, 32'hFFFF_FFFC, 1'b0, 0, 0);   // JAL to top of memory
      run_instr(32'h0050_0093, 32'h0, 1'b0, 0, 0);           // ADDI, pc wraps to 0
      run_instr(32'h0000_0063, 32'h0000_0302, 1'b0, 0, 0);   // misaligned target, not taken
      run_instr(32'h0000_0063, 32'h0000_0302, 1'b1, 0, 0);   // misaligned taken branch -> TRAP
      run_instr(32'h0040_00ef, 32'h0000_0302, 1'b0, 0, 0);   // misaligned JAL -> TRAP
      run_instr(32'h0000_007f, 32'h0, 1'b0, 0, 0);           // illegal opcode -> TRAP
      run_instr(32'h0000_0073, 32'h0, 1'b0, 1, 0);           // ECALL -> TRAP

      // Reset while MEM is acknowledging a load: nothing retires, fetch restarts at RST_PC.
      wait_imem(ok);
      check("midop_fetch", 32'(imem_req), 32'd1);
      imem_ack   = 1'b1;
      imem_rdata = 32'h0000_a103;
      @(posedge clk); #1;
      imem_ack = 1'b0;
      wait_dmem(ok);
      check("midop_in_mem", 32'(dmem_req), 32'd1);
      dmem_ack = 1'b1;
      rst_n    = 1'b0;
      #1;
      check("midop_no_retire", 32'({retire, rf_we}), 32'd0);
      @(posedge clk); #1;
      check("midop_pc", pc, RST_PC);
      do_reset(1);
      run_instr(32'h0050_0093, 32'h0, 1'b0, 0, 0);

      for (int i = 0; i < 300; i++) begin
         instr      = $urandom;
         instr[6:0] = pick_op($urandom_range(0, 13));
         tgt        = $urandom;
         if ($urandom_range(0, 7) != 0) tgt[1:0] = 2'b00;
         run_instr(instr, tgt, 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3), $urandom_range(0, 3));
      end

      repeat (6) @(posedge clk);
      #1;
      check("scoreboard_empty_at_end", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
